// File: rtl/d_asyc_pkg.sv
`timescale 1ns/1ps
// d_asyc_pkg: shared width-legality helper for the d_asyc register.
// Latency: none (constants and an elaboration-time function only).
// Backpressure: not applicable.
package d_asyc_pkg;

  // Narrowest register that makes sense: a single flag bit.
  localparam int unsigned MIN_WIDTH = 1;

  // True when a requested register width can be built.
  function automatic logic width_legal(input int width);
    return (width >= int'(MIN_WIDTH));
  endfunction

endpackage

// File: rtl/d_asyc_bit.sv
`timescale 1ns/1ps
// d_asyc_bit: one D flop with asynchronous active-high clear/preset.
// Latency: one rising clk edge d->q; reset->q is immediate (async).
// Backpressure: none; loads d on every non-reset rising edge.
module d_asyc_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic q_q;

  // Async reset selects clear or preset; otherwise capture d each rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= d;
    end
  end

  // q comes straight from the flop, no combinational path from inputs.
  assign q = q_q;

endmodule

// File: rtl/d_asyc.sv
`timescale 1ns/1ps
// d_asyc: WIDTH-bit D register with asynchronous active-high reset.
// Latency: one rising clk edge d->q; reset forces RESET_VALUE immediately.
// Backpressure: none; a new value is accepted every clock.
module d_asyc
  import d_asyc_pkg::*;
#(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reject zero/negative widths at elaboration.
  if (!width_legal(WIDTH)) begin : g_width_check
    $error("d_asyc: WIDTH must be at least %0d", MIN_WIDTH);
  end

  // Every bit is an independent flop with its own clear/preset choice.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_asyc_bit #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .d     (d[i]),
      .q     (q[i])
    );
  end

`ifndef SYNTHESIS
  // An unknown reset leaves the register state meaningless.
  always @(reset) begin
    if ($isunknown(reset)) begin
      $error("d_asyc: reset is X/Z");
    end
  end

  // An unknown d loaded at a real capture edge propagates X downstream.
  always @(posedge clk) begin
    if (reset === 1'b0 && $isunknown(d)) begin
      $warning("d_asyc: X on d sampled at capture edge");
    end
  end
`endif

endmodule

// File: tb/tb_d_asyc.sv
`timescale 1ns/1ps
// tb_d_asyc: directed and randomized checks of d_asyc (1-bit default and 8-bit A5 preset).
// Latency: expects q to follow d one rising edge later, reset immediately.
// Backpressure: none.
module tb_d_asyc;

  logic       clk;
  logic       reset;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int total;
  int bad;

  localparam logic [7:0] RV8 = 8'hA5;

  // Reference state: what each register should hold right now.
  logic       exp1;
  logic [7:0] exp8;

  d_asyc u_dut1 (
    .clk   (clk),
    .reset (reset),
    .d     (d1),
    .q     (q1)
  );

  d_asyc #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .d     (d8),
    .q     (q8)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_q1"}, {7'b0, q1}, {7'b0, exp1});
    check({tag, "_q8"}, q8, exp8);
  endtask

  initial begin
    logic seq [4];
    total = 0;
    bad   = 0;
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b1;

    // Power-up, then reset asserted exactly on the edge at 100 with d=1.
    reset = 1'b0; d1 = 1'b0; d8 = 8'h00;
    #100;
    reset = 1'b1; d1 = 1'b1; d8 = 8'hFF;
    exp1 = 1'b0; exp8 = RV8;
    #50;  // t=150
    check_both("reset_on_edge");

    // Release between edges: value stays at reset value until an edge.
    #50;  // t=200
    reset = 1'b0; d1 = 1'b0; d8 = 8'h00;
    #50;  // t=250
    check_both("release_hold");

    // Reset rises together with the edge at 300 while d=1.
    #50;  // t=300
    reset = 1'b1; d1 = 1'b1; d8 = 8'h5A;
    #50;  // t=350
    check_both("reset_coincident");
    #200; // t=550, edge at 500 ignored
    check_both("reset_held_500");
    #200; // t=750, edge at 700 ignored
    check_both("reset_held_700");

    // Release on a falling edge; nothing loads until the next rising edge.
    #50;  // t=800
    reset = 1'b0; d1 = 1'b1; d8 = 8'h3C;
    #50;  // t=850
    check_both("release_before_edge");
    @(posedge clk); #1;
    exp1 = 1'b1; exp8 = 8'h3C;
    check_both("first_capture");

    // Normal capture 1,0,1,1: q follows one edge later, falling edges inert.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d1 = seq[i];
      d8 = {4{i[1:0]}};
      #1;
      check_both("fall_no_change");
      @(posedge clk); #1;
      exp1 = seq[i];
      exp8 = {4{i[1:0]}};
      check_both("seq_capture");
    end

    // Mid-cycle async reset pulse with q=1; q must drop inside the pulse.
    @(negedge clk);
    d1 = 1'b1; d8 = 8'hC3;
    #20 reset = 1'b1;
    #10;
    exp1 = 1'b0; exp8 = RV8;
    check_both("pulse_inside");
    #10 reset = 1'b0;
    #1;
    check_both("pulse_after_release");
    @(posedge clk); #1;
    exp1 = 1'b1; exp8 = 8'hC3;
    check_both("pulse_reload");

    // Random phase: q is the last d seen at a rising edge unless a reset pulse followed it.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      #1;
      check_both("rnd_fall");
      if ($urandom_range(0, 4) == 0) begin
        #19 reset = 1'b1;
        #10;
        exp1 = 1'b0; exp8 = RV8;
        check_both("rnd_pulse");
        #10 reset = 1'b0;
      end
      @(posedge clk); #1;
      exp1 = d1;
      exp8 = d8;
      check_both("rnd_capture");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
